pe_mac_sys: RTL and testbench
=============================

// Module: pe_mac_sys
// PURPOSE
//  Parametrised processing element for the systolic-array CNN accelerator.
//  Supports weight-stationary (WS) and output-stationary (OS) dataflows, with a double-buffered weight register.
//  Supports signed or unsigned operands and an optionally saturating accumulator.
//  Tiled in a 2-D grid: features flow east, weights flow south (OS), partial sums flow south (WS).
// PARAMETERS
//  DW   8   feature/weight width in bits
//  AW   24  accumulator/partial-sum width in bits; AW >= 2*DW
//  SAT  1   1 = saturate at the AW range, 0 = two's-complement wrap
// PORTS
//  Clk        in   1   clock, rising edge
//  Rst_n      in   1   asynchronous reset, active low
//  Sclr       in   1   synchronous clear, active high
//  os_mode    in   1   0 = WS dataflow, 1 = OS dataflow
//  sgn        in   1   1 = operands and accumulator signed, 0 = unsigned
//  F_in       in   DW  feature input from the west
//  F_vld      in   1   F_in valid
//  W_in       in   DW  weight input (WS: shadow-load data; OS: streamed weight)
//  W_vld      in   1   W_in valid (OS only)
//  W_ld       in   1   WS: load W_in into the shadow register
//  W_swap     in   1   WS: copy the shadow register into the active register
//  C_in       in   AW  WS partial-sum input from the north
//  drain      in   1   OS: emit the accumulator and clear it
//  F_out      out  DW  registered F_in to the east
//  F_vld_out  out  1   registered F_vld
//  W_out      out  DW  registered W_in to the south
//  W_vld_out  out  1   registered W_vld
//  P_out      out  AW  WS partial sum / OS drained result
//  P_vld      out  1   P_out valid, single-cycle pulse per result
//  sat_flag   out  1   sticky; set when any saturation or wrap event occurs
// BEHAVIOUR
//  - Rst_n low:
//    - all outputs, the accumulator, W_shadow and W_act go to 0 immediately.
//    - Any operation in progress is lost.
//  - Sclr high (sync, priority over all other inputs):
//    - clears the accumulator, P_out, P_vld, F/W pass-through registers and sat_flag.
//    - W_shadow and W_act are retained.
//  - Pass-through: F_out/F_vld_out and W_out/W_vld_out are registered copies of their inputs.
//    - Latency is exactly 1 cycle, updated every cycle regardless of mode.
//  - Product: prod = F_in*W, 2*DW bits.
//    - sgn=1: operands signed, product sign-extended to AW.
//    - sgn=0: zero-extended.
//  - WS mode (os_mode=0):
//    - F_vld=1: P_out <= lim(prod(F_in, W_act) + C_in), P_vld <= 1 next cycle.
//    - F_vld=0: P_vld <= 0, P_out holds.
//    - W_ld: W_shadow <= W_in. W_swap: W_act <= W_shadow.
//    - W_ld and W_swap in the same cycle: W_act takes the OLD shadow; the shadow takes W_in.
//    - W_swap with F_vld in the same cycle: the MAC uses the OLD W_act. The new weight applies from the next cycle.
//  - OS mode (os_mode=1):
//    - F_vld & W_vld: acc <= lim(acc + prod(F_in, W_in)).
//    - Only one of F_vld/W_vld high: no accumulate, no error.
//    - drain: P_out <= current acc, P_vld <= 1, acc <= 0.
//    - drain with a valid MAC in the same cycle: P_out <= lim(acc + prod), acc <= 0.
//    - W_ld/W_swap are ignored; C_in is ignored.
//  - lim():
//    - SAT=1, sgn=1: clamp to [-2^(AW-1), 2^(AW-1)-1].
//    - SAT=1, sgn=0: clamp to [0, 2^AW-1].
//    - SAT=0: wrap.
//    - sat_flag <= 1 whenever clamping (SAT=1) or overflow (SAT=0) occurs; held until Sclr or reset.
//  - Switching os_mode is legal only with no valid input in flight.
//    - On a switch, acc and weights are retained and P_vld is 0 in the switch cycle.
//  - No internal FSM beyond the acc/weight registers; throughput is one MAC per cycle, no back-pressure.
// TESTING  (DW=8, AW=20)
//  1. WS unsigned:
//     - Stimulus: W_ld=3, then W_swap; F_in=200, F_vld=1, C_in=100.
//     - Response: next cycle P_out=700, P_vld=1; F_out=200, F_vld_out=1.
//  2. WS signed (sgn=1):
//     - Stimulus: W_act=0xFE (-2), F_in=0x80 (-128), C_in=-5.
//     - Response: P_out=251, sat_flag=0.
//  3. Weight double-buffer:
//     - Stimulus: W_act=2, shadow=4; same cycle W_ld=9, W_swap=1, F_in=10, C_in=0.
//     - Response: P_out=20. Next F_in=10 gives P_out=40; after another swap, F_in=10 gives 90.
//  4. OS accumulate:
//     - Stimulus: 4 beats F=10, W=5, then drain.
//     - Response: P_out=200, P_vld for 1 cycle, acc=0.
//     - Repeat with drain on the 5th beat: P_out=250.
//  5. Saturation (sgn=1):
//     - Stimulus: WS, C_in=524272, F=127, W=127.
//     - SAT=1 response: P_out=524287, sat_flag=1 and sticky until Sclr.
//     - SAT=0 response: P_out=-508175, sat_flag=1.
//  6. Reset/clear mid-operation:
//     - Sclr during OS accumulate: acc=0, P_vld=0, W_act retained.
//     - Rst_n low asynchronously: all outputs and weights are 0 before the next edge.

Source files
------------

// File: rtl/pe_mac_sys.sv
// pe_mac_sys: one processing element of the systolic CNN array.
// Multiplies a feature by a weight and adds either a partial sum from the north (WS) or its own
// accumulator (OS). It can work signed or unsigned, and it can saturate or wrap the result.
// Features and weights are re-registered so that neighbouring PEs can be chained.
module pe_mac_sys #(
  parameter int DW  = 8,
  parameter int AW  = 24,
  parameter int SAT = 1
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Sclr,
  input  logic          os_mode,
  input  logic          sgn,
  input  logic [DW-1:0] F_in,
  input  logic          F_vld,
  input  logic [DW-1:0] W_in,
  input  logic          W_vld,
  input  logic          W_ld,
  input  logic          W_swap,
  input  logic [AW-1:0] C_in,
  input  logic          drain,
  output logic [DW-1:0] F_out,
  output logic          F_vld_out,
  output logic [DW-1:0] W_out,
  output logic          W_vld_out,
  output logic [AW-1:0] P_out,
  output logic          P_vld,
  output logic          sat_flag
);

  // Two guard bits above AW hold the exact sum, so overflow can be seen before lim() is applied.
  localparam int EW = AW + 2;

  logic [DW-1:0]   fOut_q, fOut_d, wOut_q, wOut_d, wShadow_q, wShadow_d, wAct_q, wAct_d;
  logic            fVldOut_q, fVldOut_d, wVldOut_q, wVldOut_d;
  logic [AW-1:0]   acc_q, acc_d, pOut_q, pOut_d;
  logic            pVld_q, pVld_d, satFlag_q, satFlag_d, mode_q, mode_d;

  logic [DW-1:0]   mulW;
  logic [2*DW-1:0] prodS, prodU, prod;
  logic [AW-1:0]   addend, limited;
  logic [EW-1:0]   prodExt, addExt, sum;
  logic            overflow, macValid, modeSwitch;

  // Arithmetic: choose the operands for the mode, form the exact sum, detect overflow, then limit.
  always_comb begin
    mulW     = os_mode ? W_in : wAct_q;
    prodS    = {{DW{F_in[DW-1]}}, F_in} * {{DW{mulW[DW-1]}}, mulW};
    prodU    = {{DW{1'b0}}, F_in} * {{DW{1'b0}}, mulW};
    prod     = sgn ? prodS : prodU;
    prodExt  = sgn ? {{(EW-2*DW){prod[2*DW-1]}}, prod} : {{(EW-2*DW){1'b0}}, prod};
    addend   = os_mode ? acc_q : C_in;
    addExt   = sgn ? {{2{addend[AW-1]}}, addend} : {2'b00, addend};
    sum      = prodExt + addExt;
    if (sgn) begin
      overflow = (sum[EW-1:AW-1] != 3'b000) && (sum[EW-1:AW-1] != 3'b111);
    end else begin
      overflow = (sum[EW-1:AW] != 2'b00);
    end
    limited = sum[AW-1:0];
    if (overflow && (SAT != 0)) begin
      if (!sgn) begin
        limited = '1;
      end else if (sum[EW-1]) begin
        limited = {1'b1, {(AW-1){1'b0}}};
      end else begin
        limited = {1'b0, {(AW-1){1'b1}}};
      end
    end
    macValid   = os_mode ? (F_vld & W_vld) : F_vld;
    modeSwitch = (os_mode != mode_q);
  end

  // Next-state logic: a clear wins over everything but keeps the weights; a mode switch cycle stays idle.
  always_comb begin
    fOut_d    = F_in;
    fVldOut_d = F_vld;
    wOut_d    = W_in;
    wVldOut_d = W_vld;
    wShadow_d = wShadow_q;
    wAct_d    = wAct_q;
    acc_d     = acc_q;
    pOut_d    = pOut_q;
    pVld_d    = 1'b0;
    satFlag_d = satFlag_q;
    mode_d    = os_mode;
    if (Sclr) begin
      fOut_d    = '0;
      fVldOut_d = 1'b0;
      wOut_d    = '0;
      wVldOut_d = 1'b0;
      acc_d     = '0;
      pOut_d    = '0;
      satFlag_d = 1'b0;
    end else begin
      if (!os_mode) begin
        if (W_ld)   wShadow_d = W_in;
        if (W_swap) wAct_d    = wShadow_q;
      end
      if (!modeSwitch) begin
        if (!os_mode) begin
          if (F_vld) begin
            pOut_d    = limited;
            pVld_d    = 1'b1;
            satFlag_d = satFlag_q | overflow;
          end
        end else begin
          if (macValid) begin
            acc_d     = limited;
            satFlag_d = satFlag_q | overflow;
          end
          if (drain) begin
            pOut_d = macValid ? limited : acc_q;
            pVld_d = 1'b1;
            acc_d  = '0;
          end
        end
      end
    end
  end

  // State registers; an asynchronous reset clears everything, including both weight registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fOut_q    <= '0;
      fVldOut_q <= 1'b0;
      wOut_q    <= '0;
      wVldOut_q <= 1'b0;
      wShadow_q <= '0;
      wAct_q    <= '0;
      acc_q     <= '0;
      pOut_q    <= '0;
      pVld_q    <= 1'b0;
      satFlag_q <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      fOut_q    <= fOut_d;
      fVldOut_q <= fVldOut_d;
      wOut_q    <= wOut_d;
      wVldOut_q <= wVldOut_d;
      wShadow_q <= wShadow_d;
      wAct_q    <= wAct_d;
      acc_q     <= acc_d;
      pOut_q    <= pOut_d;
      pVld_q    <= pVld_d;
      satFlag_q <= satFlag_d;
      mode_q    <= mode_d;
    end
  end

  assign F_out     = fOut_q;
  assign F_vld_out = fVldOut_q;
  assign W_out     = wOut_q;
  assign W_vld_out = wVldOut_q;
  assign P_out     = pOut_q;
  assign P_vld     = pVld_q;
  assign sat_flag  = satFlag_q;

endmodule

// File: tb/tb_pe_mac_sys.sv
// tb_pe_mac_sys: bench for pe_mac_sys with DW=8 and AW=20.
// One saturating instance and one wrapping instance share the same stimulus.
// Expected results are queued when a beat is driven, then popped when P_vld is sampled.
module tb_pe_mac_sys;
  localparam int DW = 8;
  localparam int AW = 20;

  typedef struct packed {
    logic [AW-1:0] pSat;
    logic [AW-1:0] pWrap;
  } exp_t;

  logic          Clk = 1'b0;
  logic          Rst_n, Sclr, os_mode, sgn, F_vld, W_vld, W_ld, W_swap, drain;
  logic [DW-1:0] F_in, W_in;
  logic [AW-1:0] C_in;
  logic [DW-1:0] fOutS, wOutS, fOutW, wOutW;
  logic          fVldOutS, wVldOutS, pVldS, satS, fVldOutW, wVldOutW, pVldW, satW;
  logic [AW-1:0] pOutS, pOutW;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  pe_mac_sys #(.DW(DW), .AW(AW), .SAT(1)) dutSat (
    .Clk(Clk), .Rst_n(Rst_n), .Sclr(Sclr), .os_mode(os_mode), .sgn(sgn),
    .F_in(F_in), .F_vld(F_vld), .W_in(W_in), .W_vld(W_vld), .W_ld(W_ld), .W_swap(W_swap),
    .C_in(C_in), .drain(drain), .F_out(fOutS), .F_vld_out(fVldOutS), .W_out(wOutS),
    .W_vld_out(wVldOutS), .P_out(pOutS), .P_vld(pVldS), .sat_flag(satS));

  pe_mac_sys #(.DW(DW), .AW(AW), .SAT(0)) dutWrap (
    .Clk(Clk), .Rst_n(Rst_n), .Sclr(Sclr), .os_mode(os_mode), .sgn(sgn),
    .F_in(F_in), .F_vld(F_vld), .W_in(W_in), .W_vld(W_vld), .W_ld(W_ld), .W_swap(W_swap),
    .C_in(C_in), .drain(drain), .F_out(fOutW), .F_vld_out(fVldOutW), .W_out(wOutW),
    .W_vld_out(wVldOutW), .P_out(pOutW), .P_vld(pVldW), .sat_flag(satW));

  // Free-running clock with a 10 ns period.
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    Sclr = 0; F_vld = 0; W_vld = 0; W_ld = 0; W_swap = 0; drain = 0;
    F_in = '0; W_in = '0; C_in = '0;
  endtask

  task automatic loadWeight(input logic [DW-1:0] w);
    W_in = w; W_ld = 1; step();
    W_ld = 0; W_swap = 1; step();
    W_swap = 0;
  endtask

  task automatic test_reset();
    Rst_n = 0; os_mode = 0; sgn = 0; idle();
    F_in = 8'hAA; F_vld = 1; W_in = 8'h55; W_vld = 1; C_in = 20'h12345;
    step(); step();
    total++;
    if ({fOutS, fVldOutS, wOutS, wVldOutS, pOutS, pVldS, satS} !== '0) begin
      bad++; $display("[TB] FAIL reset_state: got F=%h W=%h P=%h vld=%b sat=%b, expected all 0",
                      fOutS, wOutS, pOutS, pVldS, satS);
    end
    idle();
    Rst_n = 1;
    step();
  endtask

  task automatic test_ws_unsigned();
    sgn = 0; os_mode = 0;
    loadWeight(8'd3);
    F_in = 8'd200; F_vld = 1; C_in = 20'd100; W_in = 8'd3;
    sb.push_back('{pSat: 20'd700, pWrap: 20'd700});
    step();
    e = sb.pop_front(); total++;
    if ({pVldS, pOutS, pVldW, pOutW} !== {1'b1, e.pSat, 1'b1, e.pWrap}) begin
      bad++; $display("[TB] FAIL ws_unsigned: got vld=%b/%b P=%0d/%0d, expected P=%0d/%0d",
                      pVldS, pVldW, pOutS, pOutW, e.pSat, e.pWrap);
    end
    total++;
    if ({fOutS, fVldOutS, wOutS, wVldOutS} !== {8'd200, 1'b1, 8'd3, 1'b0}) begin
      bad++; $display("[TB] FAIL pass_through: got F=%0d fv=%b W=%0d wv=%b, expected 200 1 3 0",
                      fOutS, fVldOutS, wOutS, wVldOutS);
    end
    F_vld = 0;
    step();
    total++;
    if ({pVldS, pOutS} !== {1'b0, 20'd700}) begin
      bad++; $display("[TB] FAIL ws_hold: got vld=%b P=%0d, expected vld=0 P=700", pVldS, pOutS);
    end
  endtask

  task automatic test_ws_signed();
    sgn = 1;
    loadWeight(8'hFE);
    F_in = 8'h80; F_vld = 1; C_in = 20'hFFFFB;
    sb.push_back('{pSat: 20'd251, pWrap: 20'd251});
    step();
    e = sb.pop_front(); total++;
    if ({pVldS, pOutS, pVldW, pOutW, satS, satW} !== {1'b1, e.pSat, 1'b1, e.pWrap, 2'b00}) begin
      bad++; $display("[TB] FAIL ws_signed: got P=%0d/%0d sat=%b/%b, expected P=%0d sat=0",
                      pOutS, pOutW, satS, satW, e.pSat);
    end
    idle();
  endtask

  task automatic test_double_buffer();
    logic [AW-1:0] expVals [3];
    expVals[0] = 20'd20; expVals[1] = 20'd40; expVals[2] = 20'd90;
    sgn = 0;
    loadWeight(8'd2);
    W_in = 8'd4; W_ld = 1; step();
    for (int i = 0; i < 3; i++) begin
      idle();
      if (i == 0) begin W_in = 8'd9; W_ld = 1; W_swap = 1; end
      if (i == 2) begin W_swap = 1; step(); W_swap = 0; end
      F_in = 8'd10; F_vld = 1; C_in = '0;
      sb.push_back('{pSat: expVals[i], pWrap: expVals[i]});
      step();
      e = sb.pop_front(); total++;
      if ({pVldS, pOutS, pVldW, pOutW} !== {1'b1, e.pSat, 1'b1, e.pWrap}) begin
        bad++; $display("[TB] FAIL double_buffer[%0d]: got vld=%b P=%0d/%0d, expected P=%0d",
                        i, pVldS, pOutS, pOutW, e.pSat);
      end
    end
    idle();
  endtask

  task automatic test_os_accumulate();
    logic [AW-1:0] expVals [4];
    expVals[0] = 20'd200; expVals[1] = 20'd0; expVals[2] = 20'd250; expVals[3] = 20'd0;
    sgn = 0; idle(); os_mode = 1;
    step();
    total++;
    if (pVldS !== 1'b0) begin
      bad++; $display("[TB] FAIL os_switch: got P_vld=%b, expected 0", pVldS);
    end
    for (int r = 0; r < 4; r++) begin
      // Rounds: 4 beats then drain, idle drain, 4 beats then drain with a beat, single-sided beats only.
      if (r != 1) begin
        for (int b = 0; b < 4; b++) begin
          F_in = 8'd10; W_in = 8'd5; F_vld = 1; W_vld = (r != 3);
          W_ld = 1; W_swap = 1;
          step();
          total++;
          if (pVldS !== 1'b0) begin
            bad++; $display("[TB] FAIL os_beat[%0d]: got P_vld=%b, expected 0", r, pVldS);
          end
        end
      end
      idle();
      if (r == 2) begin F_in = 8'd10; W_in = 8'd5; F_vld = 1; W_vld = 1; end
      drain = 1;
      sb.push_back('{pSat: expVals[r], pWrap: expVals[r]});
      step();
      e = sb.pop_front(); total++;
      if ({pVldS, pOutS, pVldW, pOutW} !== {1'b1, e.pSat, 1'b1, e.pWrap}) begin
        bad++; $display("[TB] FAIL os_drain[%0d]: got vld=%b P=%0d/%0d, expected P=%0d",
                        r, pVldS, pOutS, pOutW, e.pSat);
      end
      idle();
      step();
      total++;
      if (pVldS !== 1'b0) begin
        bad++; $display("[TB] FAIL os_pulse[%0d]: got P_vld=%b, expected 0", r, pVldS);
      end
    end
  endtask

  task automatic test_saturation();
    exp_t cases [4];
    logic [AW-1:0] cIn [4];
    logic [DW-1:0] fIn [4];
    logic          sg [4];
    cases[0] = '{pSat: 20'h7FFFF, pWrap: 20'h83EF1}; cIn[0] = 20'h7FFF0; fIn[0] = 8'd127;  sg[0] = 1;
    cases[1] = '{pSat: 20'd127,   pWrap: 20'd127};   cIn[1] = 20'h00000; fIn[1] = 8'd1;    sg[1] = 1;
    cases[2] = '{pSat: 20'hFFFFF, pWrap: 20'h07E80}; cIn[2] = 20'hFFFFF; fIn[2] = 8'd255;  sg[2] = 0;
    cases[3] = '{pSat: 20'h80000, pWrap: 20'h7C080}; cIn[3] = 20'h80000; fIn[3] = 8'h80;   sg[3] = 1;
    idle(); os_mode = 0;
    step();
    sgn = 1;
    loadWeight(8'd127);
    for (int i = 0; i < 4; i++) begin
      sgn = sg[i]; F_in = fIn[i]; C_in = cIn[i]; F_vld = 1;
      sb.push_back(cases[i]);
      step();
      e = sb.pop_front(); total++;
      if ({pVldS, pOutS, pVldW, pOutW, satS, satW} !== {1'b1, e.pSat, 1'b1, e.pWrap, 2'b11}) begin
        bad++; $display("[TB] FAIL saturation[%0d]: got P=%h/%h sat=%b/%b, expected P=%h/%h sat=1/1",
                        i, pOutS, pOutW, satS, satW, e.pSat, e.pWrap);
      end
    end
    Sclr = 1;
    step();
    total++;
    if ({satS, satW, pVldS, pOutS, fOutS, fVldOutS} !== '0) begin
      bad++; $display("[TB] FAIL sclr_sat: got sat=%b/%b vld=%b P=%h F=%h, expected all 0",
                      satS, satW, pVldS, pOutS, fOutS);
    end
    idle();
  endtask

  task automatic test_clear_mid();
    sgn = 0; idle(); os_mode = 1;
    step();
    for (int b = 0; b < 3; b++) begin
      F_in = 8'd10; W_in = 8'd5; F_vld = 1; W_vld = 1;
      if (b == 2) begin Sclr = 1; W_in = 8'd33; W_ld = 1; W_swap = 1; drain = 1; end
      step();
    end
    total++;
    if ({pVldS, pOutS, satS} !== '0) begin
      bad++; $display("[TB] FAIL sclr_os: got vld=%b P=%0d sat=%b, expected 0", pVldS, pOutS, satS);
    end
    idle(); drain = 1;
    sb.push_back('{pSat: 20'd0, pWrap: 20'd0});
    step();
    e = sb.pop_front(); total++;
    if ({pVldS, pOutS, pVldW, pOutW} !== {1'b1, e.pSat, 1'b1, e.pWrap}) begin
      bad++; $display("[TB] FAIL sclr_acc: got vld=%b P=%0d, expected P=0", pVldS, pOutS);
    end
    idle(); os_mode = 0;
    step();
    F_in = 8'd2; F_vld = 1; C_in = '0;
    sb.push_back('{pSat: 20'd254, pWrap: 20'd254});
    step();
    e = sb.pop_front(); total++;
    if ({pVldS, pOutS, pVldW, pOutW} !== {1'b1, e.pSat, 1'b1, e.pWrap}) begin
      bad++; $display("[TB] FAIL weight_retained: got vld=%b P=%0d, expected P=%0d", pVldS, pOutS, e.pSat);
    end
    idle();
  endtask

  task automatic test_reset_async();
    sgn = 0; F_in = 8'd3; F_vld = 1; C_in = '0; W_in = 8'd6; W_vld = 1;
    sb.push_back('{pSat: 20'd381, pWrap: 20'd381});
    step();
    e = sb.pop_front(); total++;
    if ({pVldS, pOutS, pVldW, pOutW} !== {1'b1, e.pSat, 1'b1, e.pWrap}) begin
      bad++; $display("[TB] FAIL pre_reset: got vld=%b P=%0d, expected P=%0d", pVldS, pOutS, e.pSat);
    end
    #2 Rst_n = 0;
    #1;
    total++;
    if ({fOutS, fVldOutS, wOutS, wVldOutS, pOutS, pVldS, satS} !== '0) begin
      bad++; $display("[TB] FAIL async_reset: got F=%h W=%h P=%h vld=%b, expected all 0",
                      fOutS, wOutS, pOutS, pVldS);
    end
    idle();
    @(negedge Clk);
    Rst_n = 1;
    step();
    F_in = 8'd10; F_vld = 1; C_in = 20'd7;
    sb.push_back('{pSat: 20'd7, pWrap: 20'd7});
    step();
    e = sb.pop_front(); total++;
    if ({pVldS, pOutS, pVldW, pOutW} !== {1'b1, e.pSat, 1'b1, e.pWrap}) begin
      bad++; $display("[TB] FAIL weights_reset: got vld=%b P=%0d, expected P=%0d", pVldS, pOutS, e.pSat);
    end
    idle();
  endtask

  // Test sequence; each task drives its own scenario and checks it.
  initial begin
    test_reset();
    test_ws_unsigned();
    test_ws_signed();
    test_double_buffer();
    test_os_accumulate();
    test_saturation();
    test_clear_mid();
    test_reset_async();
    total++;
    if (sb.size() !== 0) begin
      bad++; $display("[TB] FAIL scoreboard_empty: got %0d entries left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
